wb_mem_2_ppfifo: RTL and testbench

Wishbone-master read engine that drains two host-programmed memory blocks (bank 0 / bank 1) word by word into the write side of a ping-pong FIFO. It is the read-direction counterpart of the PPFIFO-to-memory writer. It sits between the memory arbiter and a PPFIFO whose read side feeds a streaming sink such as a video or DMA output core. Bank bookkeeping (base/size/count/empty) uses the same register map style as the writer so the control core drives both identically.

---
 rtl/wb_mem_2_ppfifo.sv | 253 +++++++++++++++++++++++++
 tb/tb_wb_mem_2_ppfifo.sv | 543 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_mem_2_ppfifo.sv
// wb_mem_2_ppfifo
// Wishbone-master read engine. Drains two host-programmed memory banks
// (bank 0 / bank 1) word by word into the write side of a ping-pong FIFO.
//
// Ports
//   clk, rst                      system clock, synchronous active-high reset
//   i_enable                      core enable
//   i_memory_N_base/size          word base address and length of bank N (size 0 = unused)
//   i_memory_N_new_data           one-cycle pulse: bank N freshly filled, rearm it
//   o_memory_N_count/empty        words left in bank N / bank N has nothing to read
//   o_read_finished               one-cycle pulse when a bank has been fully drained
//   o_mem_*, i_mem_*              Wishbone master (read only)
//   i_ppfifo_rdy/o_ppfifo_act     PPFIFO write-side buffer handshake
//   i_ppfifo_size                 capacity of the owned buffer
//   o_ppfifo_stb/o_ppfifo_data    PPFIFO write strobe and data
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no bus cycle; pick an armed bank with words left
// REQUEST  | wait for an owned FIFO buffer with room, then raise cyc/stb
// WAIT_ACK | strobe held until the slave acknowledges
// NEXT     | word stored; decide bank end / buffer full / pause / continue
// FINISHED | bank drained; o_read_finished high for this one cycle
module wb_mem_2_ppfifo (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_enable,
    input  logic [31:0] i_memory_0_base,
    input  logic [31:0] i_memory_0_size,
    input  logic        i_memory_0_new_data,
    output logic [31:0] o_memory_0_count,
    output logic        o_memory_0_empty,
    input  logic [31:0] i_memory_1_base,
    input  logic [31:0] i_memory_1_size,
    input  logic        i_memory_1_new_data,
    output logic [31:0] o_memory_1_count,
    output logic        o_memory_1_empty,
    output logic        o_read_finished,
    output logic        o_mem_we,
    output logic        o_mem_stb,
    output logic        o_mem_cyc,
    output logic [3:0]  o_mem_sel,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_dat,
    input  logic [31:0] i_mem_dat,
    input  logic        i_mem_ack,
    input  logic        i_mem_int,
    input  logic [1:0]  i_ppfifo_rdy,
    output logic [1:0]  o_ppfifo_act,
    input  logic [23:0] i_ppfifo_size,
    output logic        o_ppfifo_stb,
    output logic [31:0] o_ppfifo_data
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        REQUEST  = 3'd1,
        WAIT_ACK = 3'd2,
        NEXT     = 3'd3,
        FINISHED = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] ptr_q [2];
    logic [31:0] ptr_d [2];
    logic [1:0]  armed_q, armed_d;
    logic        bank_q, bank_d;
    logic        last_q, last_d;
    logic [23:0] fifo_cnt_q, fifo_cnt_d;
    logic        cyc_q, cyc_d;
    logic        stb_q, stb_d;
    logic [31:0] adr_q, adr_d;
    logic [1:0]  act_q, act_d;
    logic        pf_stb_q, pf_stb_d;
    logic [31:0] pf_data_q, pf_data_d;
    logic        fin_q, fin_d;

    logic [31:0] base  [2];
    logic [31:0] size  [2];
    logic [31:0] count [2];
    logic        busy;
    logic        pref;

    logic        unused_int;
    assign unused_int = i_mem_int;

    assign base[0] = i_memory_0_base;
    assign base[1] = i_memory_1_base;
    assign size[0] = i_memory_0_size;
    assign size[1] = i_memory_1_size;

    assign count[0] = (size[0] == 32'd0) ? 32'd0 : size[0] - ptr_q[0];
    assign count[1] = (size[1] == 32'd0) ? 32'd0 : size[1] - ptr_q[1];

    assign o_memory_0_count = count[0];
    assign o_memory_1_count = count[1];
    assign o_memory_0_empty = (count[0] == 32'd0) || (size[0] == 32'd0);
    assign o_memory_1_empty = (count[1] == 32'd0) || (size[1] == 32'd0);

    // A bank is "in use" from selection until the FSM returns to IDLE;
    // rearm pulses for it during that window are dropped.
    assign busy = (state_q != IDLE);
    // Alternate between banks; last_q resets to 1 so bank 0 goes first.
    assign pref = ~last_q;

    assign o_mem_we      = 1'b0;
    assign o_mem_sel     = 4'hF;
    assign o_mem_dat     = 32'd0;
    assign o_mem_cyc     = cyc_q;
    assign o_mem_stb     = stb_q;
    assign o_mem_adr     = adr_q;
    assign o_ppfifo_act  = act_q;
    assign o_ppfifo_stb  = pf_stb_q;
    assign o_ppfifo_data = pf_data_q;
    assign o_read_finished = fin_q;

    always_comb begin
        state_d    = state_q;
        ptr_d[0]   = ptr_q[0];
        ptr_d[1]   = ptr_q[1];
        armed_d    = armed_q;
        bank_d     = bank_q;
        last_d     = last_q;
        fifo_cnt_d = fifo_cnt_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        adr_d      = adr_q;
        act_d      = act_q;
        pf_stb_d   = 1'b0;
        pf_data_d  = pf_data_q;
        fin_d      = 1'b0;

        if (i_memory_0_new_data && !(busy && bank_q == 1'b0)) begin
            ptr_d[0]   = 32'd0;
            armed_d[0] = 1'b1;
        end
        if (i_memory_1_new_data && !(busy && bank_q == 1'b1)) begin
            ptr_d[1]   = 32'd0;
            armed_d[1] = 1'b1;
        end

        // Buffer acquire runs in every state; act_q is only ever zero here
        // when no buffer is owned, so it never fights a release below.
        if (i_enable && act_q == 2'b00 && i_ppfifo_rdy != 2'b00) begin
            act_d      = i_ppfifo_rdy[0] ? 2'b01 : 2'b10;
            fifo_cnt_d = 24'd0;
        end

        case (state_q)
            IDLE: begin
                cyc_d = 1'b0;
                stb_d = 1'b0;
                if (i_enable) begin
                    if (armed_q[pref] && count[pref] != 32'd0) begin
                        bank_d  = pref;
                        state_d = REQUEST;
                    end else if (armed_q[last_q] && count[last_q] != 32'd0) begin
                        bank_d  = last_q;
                        state_d = REQUEST;
                    end
                end
            end
            REQUEST: begin
                if (!i_enable) begin
                    // Disabled before the beat started: park, keeping ptr.
                    cyc_d   = 1'b0;
                    if (fifo_cnt_q != 24'd0) act_d = 2'b00;
                    state_d = IDLE;
                end else if (act_q != 2'b00 && fifo_cnt_q < i_ppfifo_size) begin
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    adr_d   = base[bank_q] + ptr_q[bank_q];
                    state_d = WAIT_ACK;
                end else begin
                    cyc_d = 1'b0;
                end
            end
            WAIT_ACK: begin
                if (i_mem_ack && stb_q) begin
                    pf_data_d     = i_mem_dat;
                    pf_stb_d      = 1'b1;
                    ptr_d[bank_q] = ptr_q[bank_q] + 32'd1;
                    fifo_cnt_d    = fifo_cnt_q + 24'd1;
                    stb_d         = 1'b0;
                    state_d       = NEXT;
                end
            end
            NEXT: begin
                if (count[bank_q] == 32'd0) begin
                    cyc_d           = 1'b0;
                    armed_d[bank_q] = 1'b0;
                    if (fifo_cnt_q != 24'd0) act_d = 2'b00;
                    last_d          = bank_q;
                    fin_d           = 1'b1;
                    state_d         = FINISHED;
                end else if (fifo_cnt_q == i_ppfifo_size) begin
                    cyc_d   = 1'b0;
                    act_d   = 2'b00;
                    state_d = REQUEST;
                end else if (!i_enable) begin
                    cyc_d   = 1'b0;
                    if (fifo_cnt_q != 24'd0) act_d = 2'b00;
                    state_d = IDLE;
                end else begin
                    state_d = REQUEST;
                end
            end
            FINISHED: begin
                state_d = IDLE;
            end
            default: begin
                cyc_d   = 1'b0;
                stb_d   = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q[0]   <= 32'd0;
            ptr_q[1]   <= 32'd0;
            armed_q    <= 2'b00;
            bank_q     <= 1'b0;
            last_q     <= 1'b1;
            fifo_cnt_q <= 24'd0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            adr_q      <= 32'd0;
            act_q      <= 2'b00;
            pf_stb_q   <= 1'b0;
            pf_data_q  <= 32'd0;
            fin_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q[0]   <= ptr_d[0];
            ptr_q[1]   <= ptr_d[1];
            armed_q    <= armed_d;
            bank_q     <= bank_d;
            last_q     <= last_d;
            fifo_cnt_q <= fifo_cnt_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            adr_q      <= adr_d;
            act_q      <= act_d;
            pf_stb_q   <= pf_stb_d;
            pf_data_q  <= pf_data_d;
            fin_q      <= fin_d;
        end
    end

endmodule

// File: tb/tb_wb_mem_2_ppfifo.sv
// Testbench for wb_mem_2_ppfifo: Wishbone slave with programmable wait
// states, PPFIFO write-side model, and a reference model that derives the
// expected word stream and buffer fill sizes from bank base/size arithmetic.
module tb_wb_mem_2_ppfifo;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_enable = 1'b0;
    logic [31:0] i_memory_0_base = 32'd0, i_memory_0_size = 32'd0;
    logic        i_memory_0_new_data = 1'b0;
    logic [31:0] o_memory_0_count;
    logic        o_memory_0_empty;
    logic [31:0] i_memory_1_base = 32'd0, i_memory_1_size = 32'd0;
    logic        i_memory_1_new_data = 1'b0;
    logic [31:0] o_memory_1_count;
    logic        o_memory_1_empty;
    logic        o_read_finished;
    logic        o_mem_we, o_mem_stb, o_mem_cyc;
    logic [3:0]  o_mem_sel;
    logic [31:0] o_mem_adr, o_mem_dat;
    logic [31:0] i_mem_dat = 32'd0;
    logic        i_mem_ack = 1'b0;
    logic        i_mem_int = 1'b0;
    logic [1:0]  i_ppfifo_rdy = 2'b11;
    logic [1:0]  o_ppfifo_act;
    logic [23:0] i_ppfifo_size = 24'd16;
    logic        o_ppfifo_stb;
    logic [31:0] o_ppfifo_data;

    always #5 clk = ~clk;

    wb_mem_2_ppfifo dut (
        .clk(clk), .rst(rst), .i_enable(i_enable),
        .i_memory_0_base(i_memory_0_base), .i_memory_0_size(i_memory_0_size),
        .i_memory_0_new_data(i_memory_0_new_data),
        .o_memory_0_count(o_memory_0_count), .o_memory_0_empty(o_memory_0_empty),
        .i_memory_1_base(i_memory_1_base), .i_memory_1_size(i_memory_1_size),
        .i_memory_1_new_data(i_memory_1_new_data),
        .o_memory_1_count(o_memory_1_count), .o_memory_1_empty(o_memory_1_empty),
        .o_read_finished(o_read_finished),
        .o_mem_we(o_mem_we), .o_mem_stb(o_mem_stb), .o_mem_cyc(o_mem_cyc),
        .o_mem_sel(o_mem_sel), .o_mem_adr(o_mem_adr), .o_mem_dat(o_mem_dat),
        .i_mem_dat(i_mem_dat), .i_mem_ack(i_mem_ack), .i_mem_int(i_mem_int),
        .i_ppfifo_rdy(i_ppfifo_rdy), .o_ppfifo_act(o_ppfifo_act),
        .i_ppfifo_size(i_ppfifo_size), .o_ppfifo_stb(o_ppfifo_stb),
        .o_ppfifo_data(o_ppfifo_data)
    );

    int total = 0;
    int bad   = 0;

    logic [31:0] seed;
    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ seed;
    endfunction

    // ---------------- Wishbone slave ----------------
    int          wait_states = 0;
    int          wcnt = 0;
    int          ack_cnt = 0;
    int          stab_err = 0;
    logic        stb_prev = 1'b0;
    logic [31:0] held_adr = 32'd0;
    logic [31:0] got_adr[$];

    always @(negedge clk) begin
        if (i_mem_ack) begin
            i_mem_ack = 1'b0;
        end else if (o_mem_cyc && o_mem_stb) begin
            if (!stb_prev) held_adr = o_mem_adr;
            else if (o_mem_adr !== held_adr) stab_err++;
            if (wcnt >= wait_states) begin
                i_mem_ack = 1'b1;
                i_mem_dat = memf(o_mem_adr);
                wcnt = 0;
                ack_cnt++;
                got_adr.push_back(o_mem_adr);
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        stb_prev = o_mem_stb;
    end

    // ---------------- PPFIFO write-side model ----------------
    logic [31:0] got_data[$];
    int          stb_times[$];
    int          chunks[$];
    int          chunk_buf[$];
    int          drain[2] = '{0, 0};
    int          drain_fixed = 0;
    int          cur = 0;
    int          cycle_no = 0;
    int          fin_cnt = 0;
    int          cyc_seen = 0;
    int          proto_err = 0;
    logic [1:0]  act_prev = 2'b00;
    logic        fin_prev = 1'b0;

    always @(negedge clk) begin
        cycle_no++;
        if (o_ppfifo_act == 2'b11) proto_err++;
        for (int b = 0; b < 2; b++) begin
            if (o_ppfifo_act[b] && !act_prev[b]) begin
                i_ppfifo_rdy[b] = 1'b0;
                cur = 0;
            end
        end
        if (o_ppfifo_stb) begin
            if (o_ppfifo_act == 2'b00) proto_err++;
            got_data.push_back(o_ppfifo_data);
            stb_times.push_back(cycle_no);
            cur++;
            if (cur > int'(i_ppfifo_size)) proto_err++;
        end
        for (int b = 0; b < 2; b++) begin
            if (drain[b] > 0) begin
                drain[b]--;
                if (drain[b] == 0) i_ppfifo_rdy[b] = 1'b1;
            end
            if (!o_ppfifo_act[b] && act_prev[b]) begin
                if (cur != 0) begin
                    chunks.push_back(cur);
                    chunk_buf.push_back(b);
                end else if (!rst) begin
                    proto_err++;
                end
                drain[b] = (drain_fixed != 0) ? drain_fixed : int'($urandom_range(1, 20));
            end
        end
        act_prev = o_ppfifo_act;
        if (o_read_finished) begin
            fin_cnt++;
            if (fin_prev) proto_err++;
        end
        fin_prev = o_read_finished;
        if (o_mem_cyc) cyc_seen++;
    end

    // ---------------- reference model ----------------
    logic [31:0] exp_data[$];
    logic [31:0] exp_adr[$];
    int          exp_chunks[$];
    int          last_bank = 1;

    function automatic void model_bank(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_adr.push_back(base + 32'(i));
            exp_data.push_back(memf(base + 32'(i)));
        end
    endfunction

    function automatic void model_chunks(input int n, input int fsz);
        int rem;
        rem = n;
        while (rem > 0) begin
            exp_chunks.push_back((rem < fsz) ? rem : fsz);
            rem -= fsz;
        end
    endfunction

    task automatic clear_logs();
        got_data.delete(); got_adr.delete(); stb_times.delete();
        chunks.delete(); chunk_buf.delete();
        exp_data.delete(); exp_adr.delete(); exp_chunks.delete();
        fin_cnt = 0; cyc_seen = 0; ack_cnt = 0; stab_err = 0; proto_err = 0;
    endtask

    task automatic pulse_new(input bit b0, input bit b1);
        @(negedge clk);
        i_memory_0_new_data = b0;
        i_memory_1_new_data = b1;
        @(negedge clk);
        i_memory_0_new_data = 1'b0;
        i_memory_1_new_data = 1'b0;
    endtask

    task automatic wait_fin(input int n, input int budget);
        int k;
        k = 0;
        while (fin_cnt < n && k < budget) begin
            @(negedge clk);
            k++;
        end
        repeat (4) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if ({o_mem_cyc, o_mem_stb, o_mem_we, o_ppfifo_act, o_ppfifo_stb, o_read_finished} !== 7'd0) begin
            bad++;
            $display("FAIL reset_ctrl got=%b exp=0", {o_mem_cyc, o_mem_stb, o_mem_we, o_ppfifo_act, o_ppfifo_stb, o_read_finished});
        end
        total++;
        if ({o_mem_adr, o_mem_dat, o_ppfifo_data} !== 96'd0) begin
            bad++;
            $display("FAIL reset_data adr=%h dat=%h pfdata=%h exp=0", o_mem_adr, o_mem_dat, o_ppfifo_data);
        end
        total++;
        if (o_mem_sel !== 4'hF) begin
            bad++;
            $display("FAIL reset_sel got=%h exp=f", o_mem_sel);
        end
        total++;
        if (o_memory_0_empty !== 1'b1 || o_memory_0_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_empty empty=%b count=%0d exp 1/0", o_memory_0_empty, o_memory_0_count);
        end
        rst = 1'b0;
        i_enable = 1'b1;
        i_memory_0_size = 32'd5;
        clear_logs();
        repeat (20) @(negedge clk);
        total++;
        if (cyc_seen != 0) begin
            bad++;
            $display("FAIL unarmed_cyc got=%0d cycles exp=0", cyc_seen);
        end
        total++;
        if (o_memory_0_count !== 32'd5 || o_memory_0_empty !== 1'b0) begin
            bad++;
            $display("FAIL unarmed_count count=%0d empty=%b exp 5/0", o_memory_0_count, o_memory_0_empty);
        end
    endtask

    task automatic test_size_zero();
        clear_logs();
        i_memory_0_size = 32'd0;
        i_memory_0_base = $urandom;
        pulse_new(1'b1, 1'b0);
        repeat (30) @(negedge clk);
        total++;
        if (cyc_seen != 0 || fin_cnt != 0) begin
            bad++;
            $display("FAIL size0_activity cyc=%0d fin=%0d exp 0/0", cyc_seen, fin_cnt);
        end
        total++;
        if (o_memory_0_empty !== 1'b1 || o_memory_0_count !== 32'd0) begin
            bad++;
            $display("FAIL size0_empty empty=%b count=%0d exp 1/0", o_memory_0_empty, o_memory_0_count);
        end
    endtask

    task automatic test_single();
        clear_logs();
        wait_states = 0;
        i_ppfifo_size = 24'd16;
        i_memory_0_base = 32'h100;
        i_memory_0_size = 32'd4;
        model_bank(32'h100, 4);
        model_chunks(4, 16);
        pulse_new(1'b1, 1'b0);
        wait_fin(1, 400);
        last_bank = 0;
        total++;
        if (fin_cnt != 1) begin
            bad++;
            $display("FAIL single_fin got=%0d exp=1", fin_cnt);
        end
        total++;
        if (got_adr.size() != exp_adr.size() || got_data.size() != exp_data.size()) begin
            bad++;
            $display("FAIL single_len adr=%0d data=%0d exp=%0d", got_adr.size(), got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size() && i < got_adr.size(); i++) begin
            total++;
            if (got_adr[i] !== exp_adr[i] || got_data[i] !== exp_data[i]) begin
                bad++;
                $display("FAIL single_word[%0d] adr=%h data=%h exp adr=%h data=%h", i, got_adr[i], got_data[i], exp_adr[i], exp_data[i]);
            end
        end
        for (int i = 1; i < stb_times.size(); i++) begin
            total++;
            if (stb_times[i] - stb_times[i-1] != 3) begin
                bad++;
                $display("FAIL single_rate[%0d] gap=%0d exp=3", i, stb_times[i] - stb_times[i-1]);
            end
        end
        total++;
        if (chunks != exp_chunks) begin
            bad++;
            $display("FAIL single_chunks got=%p exp=%p", chunks, exp_chunks);
        end
        total++;
        if (o_memory_0_empty !== 1'b1 || o_memory_0_count !== 32'd0 || proto_err != 0) begin
            bad++;
            $display("FAIL single_end empty=%b count=%0d proto=%0d exp 1/0/0", o_memory_0_empty, o_memory_0_count, proto_err);
        end
    endtask

    task automatic test_multi_buffer();
        logic [31:0] b;
        clear_logs();
        b = $urandom;
        wait_states = $urandom_range(0, 2);
        drain_fixed = 20;
        i_ppfifo_size = 24'd4;
        i_memory_0_base = b;
        i_memory_0_size = 32'd10;
        model_bank(b, 10);
        model_chunks(10, 4);
        pulse_new(1'b1, 1'b0);
        wait_fin(1, 1500);
        last_bank = 0;
        total++;
        if (chunks != exp_chunks) begin
            bad++;
            $display("FAIL multi_chunks got=%p exp=%p", chunks, exp_chunks);
        end
        for (int i = 1; i < chunk_buf.size(); i++) begin
            total++;
            if (chunk_buf[i] == chunk_buf[i-1]) begin
                bad++;
                $display("FAIL multi_alternate[%0d] buf=%0d prev=%0d", i, chunk_buf[i], chunk_buf[i-1]);
            end
        end
        total++;
        if (got_data.size() != exp_data.size() || got_adr.size() != exp_adr.size()) begin
            bad++;
            $display("FAIL multi_len data=%0d adr=%0d exp=%0d", got_data.size(), got_adr.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size() && i < got_adr.size(); i++) begin
            total++;
            if (got_adr[i] !== exp_adr[i] || got_data[i] !== exp_data[i]) begin
                bad++;
                $display("FAIL multi_word[%0d] adr=%h data=%h exp adr=%h data=%h", i, got_adr[i], got_data[i], exp_adr[i], exp_data[i]);
            end
        end
        total++;
        if (fin_cnt != 1 || proto_err != 0) begin
            bad++;
            $display("FAIL multi_end fin=%0d proto=%0d exp 1/0", fin_cnt, proto_err);
        end
        drain_fixed = 0;
    endtask

    task automatic test_both_banks();
        logic [31:0] b0, b1;
        int first;
        clear_logs();
        b0 = $urandom;
        b1 = 32'hFFFF_FFFE;
        wait_states = $urandom_range(0, 3);
        i_ppfifo_size = 24'd16;
        i_memory_0_base = b0; i_memory_0_size = 32'd3;
        i_memory_1_base = b1; i_memory_1_size = 32'd3;
        first = (last_bank == 0) ? 1 : 0;
        if (first == 0) begin
            model_bank(b0, 3); model_bank(b1, 3);
        end else begin
            model_bank(b1, 3); model_bank(b0, 3);
        end
        model_chunks(3, 16);
        model_chunks(3, 16);
        pulse_new(1'b1, 1'b1);
        wait_fin(2, 1000);
        last_bank = 1 - first;
        total++;
        if (fin_cnt != 2) begin
            bad++;
            $display("FAIL both_fin got=%0d exp=2", fin_cnt);
        end
        total++;
        if (got_adr.size() != exp_adr.size() || got_data.size() != exp_data.size()) begin
            bad++;
            $display("FAIL both_len adr=%0d data=%0d exp=%0d", got_adr.size(), got_data.size(), exp_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size() && i < got_adr.size(); i++) begin
            total++;
            if (got_adr[i] !== exp_adr[i] || got_data[i] !== exp_data[i]) begin
                bad++;
                $display("FAIL both_word[%0d] adr=%h data=%h exp adr=%h data=%h", i, got_adr[i], got_data[i], exp_adr[i], exp_data[i]);
            end
        end
        total++;
        if (chunks != exp_chunks) begin
            bad++;
            $display("FAIL both_chunks got=%p exp=%p", chunks, exp_chunks);
        end
        total++;
        if (o_memory_0_empty !== 1'b1 || o_memory_1_empty !== 1'b1 || proto_err != 0) begin
            bad++;
            $display("FAIL both_end empty0=%b empty1=%b proto=%0d exp 1/1/0", o_memory_0_empty, o_memory_1_empty, proto_err);
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] b;
        clear_logs();
        b = $urandom;
        wait_states = 5;
        i_ppfifo_size = 24'd16;
        i_memory_0_base = b;
        i_memory_0_size = 32'd4;
        model_bank(b, 4);
        pulse_new(1'b1, 1'b0);
        wait_fin(1, 600);
        last_bank = 0;
        total++;
        if (stab_err != 0) begin
            bad++;
            $display("FAIL wait_stable got=%0d changes exp=0", stab_err);
        end
        total++;
        if (ack_cnt != 4 || got_data.size() != 4) begin
            bad++;
            $display("FAIL wait_count acks=%0d strobes=%0d exp 4/4", ack_cnt, got_data.size());
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size(); i++) begin
            total++;
            if (got_data[i] !== exp_data[i]) begin
                bad++;
                $display("FAIL wait_word[%0d] got=%h exp=%h", i, got_data[i], exp_data[i]);
            end
        end
        for (int i = 1; i < stb_times.size(); i++) begin
            total++;
            if (stb_times[i] - stb_times[i-1] != 8) begin
                bad++;
                $display("FAIL wait_rate[%0d] gap=%0d exp=8", i, stb_times[i] - stb_times[i-1]);
            end
        end
        wait_states = 0;
    endtask

    task automatic test_enable_pause();
        logic [31:0] b;
        int k, paused, sum;
        clear_logs();
        b = $urandom;
        wait_states = 0;
        i_ppfifo_size = 24'd16;
        i_memory_1_base = b;
        i_memory_1_size = 32'd6;
        model_bank(b, 6);
        pulse_new(1'b0, 1'b1);
        k = 0;
        while (got_data.size() < 2 && k < 300) begin
            @(negedge clk);
            k++;
        end
        i_enable = 1'b0;
        repeat (20) @(negedge clk);
        paused = got_data.size();
        total++;
        if (paused < 2 || paused > 3) begin
            bad++;
            $display("FAIL pause_words got=%0d exp 2..3", paused);
        end
        total++;
        if (o_mem_cyc !== 1'b0 || o_ppfifo_act !== 2'b00 || fin_cnt != 0) begin
            bad++;
            $display("FAIL pause_idle cyc=%b act=%b fin=%0d exp 0/00/0", o_mem_cyc, o_ppfifo_act, fin_cnt);
        end
        total++;
        if (o_memory_1_count !== 32'(6 - paused)) begin
            bad++;
            $display("FAIL pause_count got=%0d exp=%0d", o_memory_1_count, 6 - paused);
        end
        i_enable = 1'b1;
        wait_fin(1, 600);
        last_bank = 1;
        total++;
        if (got_data.size() != 6 || got_adr.size() != 6 || fin_cnt != 1) begin
            bad++;
            $display("FAIL resume_len data=%0d adr=%0d fin=%0d exp 6/6/1", got_data.size(), got_adr.size(), fin_cnt);
        end
        for (int i = 0; i < exp_data.size() && i < got_data.size() && i < got_adr.size(); i++) begin
            total++;
            if (got_adr[i] !== exp_adr[i] || got_data[i] !== exp_data[i]) begin
                bad++;
                $display("FAIL resume_word[%0d] adr=%h data=%h exp adr=%h data=%h", i, got_adr[i], got_data[i], exp_adr[i], exp_data[i]);
            end
        end
        sum = 0;
        foreach (chunks[i]) sum += chunks[i];
        total++;
        if (chunks.size() != 2 || sum != 6 || proto_err != 0) begin
            bad++;
            $display("FAIL resume_chunks got=%p proto=%0d exp two buffers totalling 6", chunks, proto_err);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        clear_logs();
        i_ppfifo_size = 24'd16;
        i_memory_0_base = $urandom;
        i_memory_0_size = 32'd8;
        pulse_new(1'b1, 1'b0);
        k = 0;
        while (!o_mem_cyc && k < 200) begin
            @(negedge clk);
            k++;
        end
        total++;
        if (o_mem_cyc !== 1'b1) begin
            bad++;
            $display("FAIL rstmid_start cyc=%b exp=1 (timeout)", o_mem_cyc);
        end
        rst = 1'b1;
        @(negedge clk);
        total++;
        if ({o_mem_cyc, o_mem_stb, o_ppfifo_act} !== 4'd0) begin
            bad++;
            $display("FAIL rstmid_drop cyc=%b stb=%b act=%b exp 0", o_mem_cyc, o_mem_stb, o_ppfifo_act);
        end
        total++;
        if (o_memory_0_count !== 32'd8) begin
            bad++;
            $display("FAIL rstmid_ptr count=%0d exp=8", o_memory_0_count);
        end
        @(negedge clk);
        rst = 1'b0;
        cyc_seen = 0;
        repeat (20) @(negedge clk);
        total++;
        if (cyc_seen != 0) begin
            bad++;
            $display("FAIL rstmid_disarm cyc=%0d cycles exp=0", cyc_seen);
        end
    endtask

    initial begin
        seed = $urandom;
        test_reset();
        test_size_zero();
        test_single();
        test_multi_buffer();
        test_both_banks();
        test_wait_states();
        test_enable_pause();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
